// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared constants for the run length detector
package run_det_pkg;

    // Two-state controller: no sample seen yet, or tracking a run
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Behaviour once a run reaches RUN_LEN
    localparam int MODE_SUSTAIN = 0;
    localparam int MODE_REARM   = 1;

    // Legal RUN_LEN for a given run counter width
    function automatic bit run_len_ok(input int run_len, input int cnt_w);
        return (run_len >= 2) && (run_len <= (2 ** cnt_w) - 1);
    endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// rtl/run_length_detector_if.sv - sample input and detector status bundle
interface run_length_detector_if #(
    parameter int CNT_W = 4,
    parameter int DET_W = 8
);
    logic             en;
    logic             w;
    logic             z;
    logic             z_pulse;
    logic             run_val;
    logic [CNT_W-1:0] run_cnt;
    logic [DET_W-1:0] det_cnt;

    // Sample source side
    modport master (
        output en,
        output w,
        input  z,
        input  z_pulse,
        input  run_val,
        input  run_cnt,
        input  det_cnt
    );

    // Detector side
    modport slave (
        input  en,
        input  w,
        output z,
        output z_pulse,
        output run_val,
        output run_cnt,
        output det_cnt
    );
endinterface

// File: rtl/run_length_detector_event_counter.sv
// rtl/run_length_detector_event_counter.sv - wrapping strobe counter
module event_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Advance by one per strobe; natural overflow gives the wrap to zero
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // Register the count with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - consecutive equal sample run detector
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int MODE    = 0,
    parameter int DET_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    run_length_detector_if.slave  bus
);

    if (!run_len_ok(RUN_LEN, CNT_W)) begin : g_run_len_check
        $error("RUN_LEN out of range for CNT_W");
    end

    if ((MODE != MODE_SUSTAIN) && (MODE != MODE_REARM)) begin : g_mode_check
        $error("MODE must be SUSTAIN or REARM");
    end

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             run_val_q;
    logic             run_val_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;
    logic             z_pulse_q;
    logic             z_pulse_d;

    // Next run state from the current sample; a pulse marks the entry into RUN_LEN
    always_comb begin
        state_d   = state_q;
        run_val_d = run_val_q;
        run_cnt_d = run_cnt_q;
        z_pulse_d = 1'b0;
        if (bus.en) begin
            if ((state_q == ST_IDLE) || (bus.w != run_val_q)) begin
                state_d   = ST_RUN;
                run_val_d = bus.w;
                run_cnt_d = CNT_W'(1);
            end else if (run_cnt_q != RUN_LEN_C) begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
            end else if (MODE == MODE_REARM) begin
                run_cnt_d = CNT_W'(1);
            end
            z_pulse_d = (run_cnt_d == RUN_LEN_C) && (run_cnt_q != RUN_LEN_C);
        end
    end

    // Run tracking registers with synchronous reset taking priority over en
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_val_q <= 1'b0;
            run_cnt_q <= '0;
            z_pulse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_val_q <= run_val_d;
            run_cnt_q <= run_cnt_d;
            z_pulse_q <= z_pulse_d;
        end
    end

    // Detection count advances on the same edge that raises z_pulse
    event_counter #(
        .W (DET_W)
    ) u_det_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (z_pulse_d),
        .count (bus.det_cnt)
    );

    assign bus.z       = (state_q == ST_RUN) && (run_cnt_q == RUN_LEN_C);
    assign bus.z_pulse = z_pulse_q;
    assign bus.run_val = run_val_q;
    assign bus.run_cnt = run_cnt_q;

endmodule

// File: tb/tb_run_length_detector.sv
// tb/tb_run_length_detector.sv - scoreboard bench for run_length_detector
module tb_run_length_detector;

    typedef struct {
        logic        z;
        logic        zp;
        logic        rv;
        logic [31:0] rc;
        logic [31:0] dc;
    } exp_t;

    // Three configurations: default SUSTAIN, REARM with narrow wrap, SUSTAIN at max RUN_LEN
    localparam int RL [3] = '{4, 3, 3};
    localparam int MD [3] = '{0, 1, 0};
    localparam int DW [3] = '{8, 2, 3};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic w = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int   m_len [3];
    logic m_val [3];
    int   m_det [3];

    always #5 clk = ~clk;

    run_length_detector_if #(.CNT_W(4), .DET_W(8)) if_a ();
    run_length_detector_if #(.CNT_W(4), .DET_W(2)) if_b ();
    run_length_detector_if #(.CNT_W(2), .DET_W(3)) if_c ();

    assign if_a.en = en;
    assign if_a.w  = w;
    assign if_b.en = en;
    assign if_b.w  = w;
    assign if_c.en = en;
    assign if_c.w  = w;

    run_length_detector #(.RUN_LEN(4), .CNT_W(4), .MODE(0), .DET_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    run_length_detector #(.RUN_LEN(3), .CNT_W(4), .MODE(1), .DET_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    run_length_detector #(.RUN_LEN(3), .CNT_W(2), .MODE(0), .DET_W(3)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e, input logic z, input logic zp,
                             input logic rv, input logic [31:0] rc, input logic [31:0] dc);
        chk({tag, ".z"}, {31'd0, z}, {31'd0, e.z});
        chk({tag, ".z_pulse"}, {31'd0, zp}, {31'd0, e.zp});
        chk({tag, ".run_val"}, {31'd0, rv}, {31'd0, e.rv});
        chk({tag, ".run_cnt"}, rc, e.rc);
        chk({tag, ".det_cnt"}, dc, e.dc);
    endtask

    // Reference: the model only remembers the length and value of the trailing run
    function automatic exp_t model_step(input int k, input logic r, input logic e, input logic wv);
        exp_t x;
        logic pulse;
        pulse = 1'b0;
        if (r) begin
            m_len[k] = 0;
            m_val[k] = 1'b0;
            m_det[k] = 0;
        end else if (e) begin
            if (m_len[k] == 0 || wv != m_val[k]) begin
                m_len[k] = 1;
                m_val[k] = wv;
            end else begin
                m_len[k] = m_len[k] + 1;
            end
            if (MD[k] == 0) pulse = (m_len[k] == RL[k]);
            else            pulse = (m_len[k] % RL[k] == 0);
            if (pulse) m_det[k] = (m_det[k] + 1) % (1 << DW[k]);
        end
        x.zp = pulse;
        x.rv = m_val[k];
        x.dc = 32'(m_det[k]);
        if (m_len[k] == 0) begin
            x.rc = 32'd0;
            x.z  = 1'b0;
        end else if (MD[k] == 0) begin
            x.rc = 32'((m_len[k] < RL[k]) ? m_len[k] : RL[k]);
            x.z  = (m_len[k] >= RL[k]);
        end else begin
            x.rc = 32'(((m_len[k] - 1) % RL[k]) + 1);
            x.z  = (m_len[k] % RL[k] == 0);
        end
        return x;
    endfunction

    // Drive one edge worth of inputs and queue what each DUT should show after it
    task automatic step(input logic r, input logic e, input logic wv);
        @(negedge clk);
        reset = r;
        en    = e;
        w     = wv;
        q_a.push_back(model_step(0, r, e, wv));
        q_b.push_back(model_step(1, r, e, wv));
        q_c.push_back(model_step(2, r, e, wv));
    endtask

    task automatic samples(input int n, input logic wv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, wv);
    endtask

    // Monitor: after each active edge, compare the DUT state against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_dut("a", e, if_a.z, if_a.z_pulse, if_a.run_val,
                          32'(if_a.run_cnt), 32'(if_a.det_cnt));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_dut("b", e, if_b.z, if_b.z_pulse, if_b.run_val,
                          32'(if_b.run_cnt), 32'(if_b.det_cnt));
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                check_dut("c", e, if_c.z, if_c.z_pulse, if_c.run_val,
                          32'(if_c.run_cnt), 32'(if_c.det_cnt));
            end
        end
    end

    initial begin
        int budget;
        logic wr;

        // Reset state, then four zeros
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        samples(4, 1'b0);

        // Long ones run followed by a zero
        step(1'b1, 1'b0, 1'b0);
        samples(7, 1'b1);
        samples(1, 1'b0);

        // Nine zeros, then fifteen for the narrow counter wrap
        step(1'b1, 1'b0, 1'b0);
        samples(9, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        samples(15, 1'b0);

        // en toggling with w held high
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, (i % 2) == 0, 1'b1);

        // Short zero run then a detecting ones run
        step(1'b1, 1'b0, 1'b0);
        samples(3, 1'b0);
        samples(4, 1'b1);

        // Reset mid-run with en high, then a fresh run
        step(1'b1, 1'b0, 1'b0);
        samples(3, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        samples(4, 1'b0);

        // Randomised runs with en gaps and occasional resets
        wr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) wr = ~wr;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, wr);
        end
        step(1'b0, 1'b0, 1'b0);

        budget = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) > 0 && budget < 20) begin
            @(posedge clk);
            #2;
            budget++;
        end
        n_checks++;
        if ((q_a.size() + q_b.size() + q_c.size()) > 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 entries left",
                     q_a.size() + q_b.size() + q_c.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
